// File: rtl/adder_pkg.sv
// Shared definitions for the serial block adder.
//   sba_state_t  : controller states (IDLE, RUN, DONE)
//   num_blocks() : number of BLOCK_SIZE-wide slices covering an n-bit operand
//   idx_width()  : width of a slice index counter, never less than one bit
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sba_state_t;

  function automatic int unsigned num_blocks(input int unsigned n, input int unsigned bs);
    return (n + bs - 1) / bs;
  endfunction

  function automatic int unsigned idx_width(input int unsigned nb);
    return (nb > 1) ? int'($clog2(nb)) : 1;
  endfunction

endpackage

// File: rtl/carry_skip_adder.sv
// Combinational carry-skip adder.
//   a, b  : N-bit operands
//   cin   : carry in
//   sum   : a + b + cin modulo 2^N
//   cout  : carry out of bit N-1
// Bits ripple inside each BLOCK_SIZE block; a block whose bits all propagate
// passes its incoming carry straight through to the next block.
module carry_skip_adder
  import adder_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NBK = num_blocks(N, BLOCK_SIZE);

  logic c_blk;   // carry entering the current block
  logic c_bit;   // ripple carry inside the current block
  logic p_all;   // every bit of the current block propagates

  always_comb begin
    sum   = '0;
    c_blk = cin;
    c_bit = 1'b0;
    p_all = 1'b1;
    for (int unsigned k = 0; k < NBK; k++) begin
      c_bit = c_blk;
      p_all = 1'b1;
      for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
        if (k * BLOCK_SIZE + j < N) begin
          sum[k*BLOCK_SIZE+j] = a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j] ^ c_bit;
          c_bit = (a[k*BLOCK_SIZE+j] & b[k*BLOCK_SIZE+j]) |
                  (c_bit & (a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j]));
          p_all = p_all & (a[k*BLOCK_SIZE+j] ^ b[k*BLOCK_SIZE+j]);
        end
      end
      // A fully propagating block cannot generate, so the skip path is exact.
      c_blk = p_all ? c_blk : c_bit;
    end
    cout = c_blk;
  end

endmodule

// File: rtl/serial_block_adder.sv
// Multi-cycle N-bit adder: one BLOCK_SIZE slice per cycle through a single
// carry_skip_adder, LSB slice first, with the slice carry registered between
// cycles.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin captured in IDLE)
//   out_valid / out_ready: result handshake (sum, cout held in DONE)
//   sum, cout            : registered a + b + cin and carry out of bit N-1
module serial_block_adder
  import adder_pkg::*;
#(
  parameter int unsigned N          = 16,
  parameter int unsigned BLOCK_SIZE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NB  = num_blocks(N, BLOCK_SIZE);
  localparam int unsigned IW  = idx_width(NB);
  localparam int unsigned PW  = NB * BLOCK_SIZE;   // operand width padded to whole slices
  localparam int unsigned Rem = N % BLOCK_SIZE;

  localparam logic [IW-1:0] LastIdx   = IW'(NB - 1);
  localparam logic [PW-1:0] SliceMask = PW'({BLOCK_SIZE{1'b1}});

  sba_state_t state_q;
  logic [IW-1:0] idx_q;
  logic [PW-1:0] a_q, b_q;
  logic          carry_q;
  logic [N-1:0]  sum_q;
  logic          cout_q;

  logic [31:0]           off;
  logic [BLOCK_SIZE-1:0] slice_a, slice_b, slice_sum;
  logic                  slice_cout;
  logic [N-1:0]          sum_d;
  logic                  cout_last;

  // Padding bits above N-1 are zero in the operand registers, so the last
  // slice sees zeros there.
  assign off     = 32'(idx_q) * BLOCK_SIZE;
  assign slice_a = BLOCK_SIZE'(a_q >> off);
  assign slice_b = BLOCK_SIZE'(b_q >> off);

  carry_skip_adder #(
    .N          (BLOCK_SIZE),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_csa (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    sum_d = N'((PW'(sum_q) & ~(SliceMask << off)) | (PW'(slice_sum) << off));
    // With a partial last slice the true carry out of bit N-1 lands on slice
    // sum bit Rem, since the padded operand bits are zero.
    cout_last = (Rem == 0) ? slice_cout : 1'(slice_sum >> Rem);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= PW'(a);
            b_q     <= PW'(b);
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_d;
          carry_q <= slice_cout;
          if (idx_q == LastIdx) begin
            cout_q  <= cout_last;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_block_adder.sv
// Bench for serial_block_adder with three instances sharing the operand bus:
// inst 0 N=16, inst 1 N=10 (padded last slice), inst 2 N=4 (single slice).
// A per-instance cycle model predicts in_ready/out_valid timing and the
// result of each accepted operand pair; directed sequences add literal values.
module tb_serial_block_adder;

  logic        clk;
  logic        rst_n;
  logic [15:0] a_bus, b_bus;
  logic        cin_bus;
  logic [2:0]  in_valid_r, out_ready_r;
  logic [2:0]  ir_w, ov_w, cout_w;
  logic [2:0][15:0] sum_w;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int pcnt     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  for (genvar G = 0; G < 3; G++) begin : g_inst
    localparam int unsigned W   = (G == 0) ? 16 : ((G == 1) ? 10 : 4);
    localparam int unsigned NBW = (W + 3) / 4;

    logic [W-1:0] s;
    logic         co, ir, ov;

    serial_block_adder #(
      .N          (W),
      .BLOCK_SIZE (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_r[G]),
      .in_ready  (ir),
      .a         (a_bus[W-1:0]),
      .b         (b_bus[W-1:0]),
      .cin       (cin_bus),
      .out_valid (ov),
      .out_ready (out_ready_r[G]),
      .sum       (s),
      .cout      (co)
    );

    assign sum_w[G]  = 16'(s);
    assign cout_w[G] = co;
    assign ir_w[G]   = ir;
    assign ov_w[G]   = ov;

    // Cycle model: a pair seen with in_ready at negedge t is taken at the next
    // rising edge; the result is shown from negedge t+NBW+1 until out_ready.
    int           cyc   = 0;
    int           acc_t = 0;
    bit           busy  = 1'b0;
    logic [W-1:0] es;
    logic         ec;
    logic [W:0]   tot;

    always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
        busy = 1'b0;
        chk($sformatf("rst_outv%0d", G), ov, 1'b0);
        chk($sformatf("rst_sum%0d", G), s, '0);
        chk($sformatf("rst_cout%0d", G), co, 1'b0);
        chk($sformatf("rst_inrdy%0d", G), ir, 1'b1);
      end else if (busy) begin
        chk($sformatf("busy_inrdy%0d", G), ir, 1'b0);
        if (cyc - acc_t <= int'(NBW)) begin
          chk($sformatf("run_outv%0d", G), ov, 1'b0);
        end else begin
          chk($sformatf("done_outv%0d", G), ov, 1'b1);
          chk($sformatf("done_sum%0d", G), s, es);
          chk($sformatf("done_cout%0d", G), co, ec);
          if (out_ready_r[G]) busy = 1'b0;
        end
      end else begin
        chk($sformatf("idle_inrdy%0d", G), ir, 1'b1);
        chk($sformatf("idle_outv%0d", G), ov, 1'b0);
        if (in_valid_r[G]) begin
          busy  = 1'b1;
          acc_t = cyc;
          tot   = {1'b0, a_bus[W-1:0]} + {1'b0, b_bus[W-1:0]} + {{W{1'b0}}, cin_bus};
          es    = tot[W-1:0];
          ec    = tot[W];
        end
      end
    end
  end

  task automatic send(input int g, input logic [15:0] av, input logic [15:0] bv,
                      input logic c);
    int n = 0;
    a_bus = av;
    b_bus = bv;
    cin_bus = c;
    in_valid_r[g] = 1'b1;
    while (!ir_w[g] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("send_ready%0d", g), ir_w[g], 1'b1);
    @(posedge clk); #1;
    in_valid_r[g] = 1'b0;
  endtask

  // Counts rising edges from now until out_valid is seen.
  task automatic wait_valid(input int g, output int k);
    k = 0;
    while (!ov_w[g] && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int first_p, last_p;

    rst_n = 1'b0;
    a_bus = '0;
    b_bus = '0;
    cin_bus = 1'b0;
    in_valid_r = '0;
    out_ready_r = '1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", ir_w[0], 1'b1);
    chk("reset_out_valid", ov_w[0], 1'b0);
    chk("reset_sum", sum_w[0], 16'h0000);
    chk("reset_cout", cout_w[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry ripple across all four slices; latency is NB edges.
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    wait_valid(0, k);
    chk("lat_nb4", k, 4);
    chk("ffff_sum", sum_w[0], 16'h0000);
    chk("ffff_cout", cout_w[0], 1'b1);
    @(posedge clk); #1;

    // Backpressure: result held stable for three cycles in DONE.
    out_ready_r[0] = 1'b0;
    send(0, 16'h1234, 16'h4321, 1'b1);
    wait_valid(0, k);
    chk("bp_sum", sum_w[0], 16'h5556);
    chk("bp_cout", cout_w[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", ov_w[0], 1'b1);
      chk("bp_hold_sum", sum_w[0], 16'h5556);
      chk("bp_hold_inrdy", ir_w[0], 1'b0);
    end
    out_ready_r[0] = 1'b1;
    chk("bp_inrdy_same_cycle", ir_w[0], 1'b0);
    @(posedge clk); #1;
    chk("bp_inrdy_after", ir_w[0], 1'b1);

    // N=10: padded last slice.
    send(1, 16'h03FF, 16'h0001, 1'b0);
    wait_valid(1, k);
    chk("n10_sum0", sum_w[1], 16'h0000);
    chk("n10_cout1", cout_w[1], 1'b1);
    @(posedge clk); #1;
    send(1, 16'h0200, 16'h0100, 1'b0);
    wait_valid(1, k);
    chk("n10_sum300", sum_w[1], 16'h0300);
    chk("n10_cout0", cout_w[1], 1'b0);
    @(posedge clk); #1;

    // in_valid held with a changing bus during RUN must not disturb the result.
    send(0, 16'h1111, 16'h2222, 1'b0);
    in_valid_r[0] = 1'b1;
    k = 0;
    while (!ov_w[0] && k < 50) begin
      a_bus = 16'($urandom);
      b_bus = 16'($urandom);
      cin_bus = 1'($urandom);
      @(posedge clk); #1;
      k++;
    end
    chk("ign_sum", sum_w[0], 16'h3333);
    chk("ign_cout", cout_w[0], 1'b0);
    in_valid_r[0] = 1'b0;
    @(posedge clk); #1;

    // Reset while idx=2: outputs clear at once and nothing stale appears.
    send(0, 16'hABCD, 16'h1111, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outv", ov_w[0], 1'b0);
    chk("mid_rst_sum", sum_w[0], 16'h0000);
    chk("mid_rst_cout", cout_w[0], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", ov_w[0], 1'b0);
    end
    send(0, 16'h0F0F, 16'h00F1, 1'b0);
    wait_valid(0, k);
    chk("post_rst_sum", sum_w[0], 16'h1000);
    chk("post_rst_cout", cout_w[0], 1'b0);
    @(posedge clk); #1;

    // N=4 single slice: every a, b, cin combination at one result per 3 cycles.
    first_p = 0;
    last_p = 0;
    for (int i = 0; i < 512; i++) begin
      send(2, 16'(i[3:0]), 16'(i[7:4]), i[8]);
      if (i == 0) first_p = pcnt;
      last_p = pcnt;
    end
    chk("nb1_throughput", 32'(last_p - first_p), 32'(511 * 3));
    wait_valid(2, k);
    chk("nb1_last_sum", sum_w[2], 16'h000F);
    chk("nb1_last_cout", cout_w[2], 1'b1);
    @(posedge clk); #1;

    // Random traffic on inst 0 and 1 with random handshakes.
    for (int i = 0; i < 400; i++) begin
      a_bus = 16'($urandom);
      b_bus = 16'($urandom);
      cin_bus = 1'($urandom);
      in_valid_r[0] = 1'($urandom);
      in_valid_r[1] = 1'($urandom);
      out_ready_r[0] = ($urandom_range(3) != 0);
      out_ready_r[1] = ($urandom_range(3) != 0);
      @(posedge clk); #1;
    end
    in_valid_r = '0;
    out_ready_r = '1;
    repeat (20) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
